// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, FSM state type and width helpers for the MEM stage.
`default_nettype none

package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REQ      = 2'd1,
      S_WAIT_RSP = 2'd2
   } state_e;

   localparam int BE_W_DEFAULT = 4;

   function automatic int be_width(input int xlen);
      return xlen / 8;
   endfunction

   // Double-word accesses do not exist on a 32-bit datapath; they degrade to word.
   function automatic logic [1:0] eff_size(input logic [1:0] sz, input int xlen);
      return (xlen == 32 && sz == 2'b11) ? 2'b10 : sz;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/response channel between the MEM stage and memory.
`default_nettype none

interface mem_access_stage_if
   import mem_pkg::*;
#(
   parameter int XLEN = 32
);
   localparam int BE_W = be_width(XLEN);

   logic            req_valid;
   logic            req_ready;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [BE_W-1:0] be;
   logic            rsp_valid;
   logic [XLEN-1:0] rdata;

   modport master (
      output req_valid, we, addr, wdata, be,
      input  req_ready, rsp_valid, rdata
   );

   modport slave (
      input  req_valid, we, addr, wdata, be,
      output req_ready, rsp_valid, rdata
   );

endinterface

`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
// load_align: picks the addressed lane out of a load word and sign/zero-extends it.
`default_nettype none

module load_align
   import mem_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int LANE_W = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0]   rdata_i,
   input  logic [LANE_W-1:0] lane_i,
   input  logic [2:0]        funct3_i,
   output logic [XLEN-1:0]   data_o
);

   logic [XLEN-1:0] sh;
   logic [XLEN-1:0] mask;
   logic            sgn;
   logic [1:0]      sz;

   always_comb begin
      sz   = eff_size(funct3_i[1:0], XLEN);
      sh   = rdata_i >> {lane_i, 3'b000};
      mask = '1;
      sgn  = 1'b0;
      case (sz)
         2'b00:   begin mask = XLEN'(64'hFF);        sgn = sh[7];  end
         2'b01:   begin mask = XLEN'(64'hFFFF);      sgn = sh[15]; end
         2'b10:   begin mask = XLEN'(64'hFFFF_FFFF); sgn = sh[31]; end
         default: ;
      endcase
      // funct3[2] selects the unsigned variants
      sgn    = sgn & ~funct3_i[2];
      data_o = (sh & mask) | ({XLEN{sgn}} & ~mask);
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with sub-word loads/stores and memory-latency stall.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of being silently aligned.
`default_nettype none

module mem_access_stage
   import mem_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [XLEN-1:0]   alu_result_in,
   input  logic [XLEN-1:0]   rs2_data_in,
   input  logic [RA_W-1:0]   rd_addr_in,
   input  logic [XLEN-1:0]   pc_plus_4_in,
   input  logic [2:0]        funct3_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   output logic              stall_out,
   mem_access_stage_if.master dmem,
   output logic              out_valid,
   output logic [XLEN-1:0]   alu_result_out,
   output logic [XLEN-1:0]   read_data_out,
   output logic [RA_W-1:0]   rd_addr_out,
   output logic [XLEN-1:0]   pc_plus_4_out,
   output logic              reg_write_out,
   output logic              mem_to_reg_out
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_fault_out
`endif
);

   localparam int BE_W   = be_width(XLEN);
   localparam int LANE_W = $clog2(XLEN/8);

   function automatic logic [LANE_W-1:0] align_lane(input logic [LANE_W-1:0] lane,
                                                    input logic [1:0] sz);
      logic [LANE_W-1:0] m;
      m = LANE_W'((1 << sz) - 1);
      return lane & ~m;
   endfunction

   state_e            state_q, state_d;
   logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
   logic [RA_W-1:0]   rd_q, rd_d;
   logic [2:0]        f3_q, f3_d;
   logic              store_q, store_d, rw_q, rw_d, m2r_q, m2r_d;
   logic              ov_q, ov_d, rwo_q, rwo_d, m2ro_q, m2ro_d;
   logic [XLEN-1:0]   alu_o_q, alu_o_d, rd_data_q, rd_data_d, pc_o_q, pc_o_d;
   logic [RA_W-1:0]   rd_o_q, rd_o_d;

   logic [1:0]        sz;
   logic [LANE_W-1:0] lane;
   logic [BE_W-1:0]   be_base;
   logic [XLEN-1:0]   wdata_rep;
   logic [XLEN-1:0]   load_data;
   logic              in_mem;
   logic              trap_hit;
   logic              req;

   assign sz     = eff_size(f3_q[1:0], XLEN);
   assign lane   = align_lane(addr_q[LANE_W-1:0], sz);
   assign in_mem = mem_read_in | mem_write_in;
   assign req    = (state_q == S_REQ);

`ifdef MEM_MISALIGN_TRAP_EN
   logic [1:0] in_sz;
   logic       fault_q;
   assign in_sz    = eff_size(funct3_in[1:0], XLEN);
   assign trap_hit = alu_result_in[LANE_W-1:0] != align_lane(alu_result_in[LANE_W-1:0], in_sz);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fault_q <= 1'b0;
      else        fault_q <= (state_q == S_IDLE) && in_valid && in_mem && trap_hit;
   end
   assign misalign_fault_out = fault_q;
`else
   assign trap_hit = 1'b0;
`endif

   always_comb begin
      be_base = '1;
      wdata_rep = wdata_q;
      case (sz)
         2'b00:   begin be_base = BE_W'(1);  wdata_rep = {(XLEN/8){wdata_q[7:0]}};   end
         2'b01:   begin be_base = BE_W'(3);  wdata_rep = {(XLEN/16){wdata_q[15:0]}}; end
         2'b10:   begin be_base = BE_W'(15); wdata_rep = {(XLEN/32){wdata_q[31:0]}}; end
         default: ;
      endcase
   end

   load_align #(.XLEN(XLEN), .LANE_W(LANE_W)) u_load_align (
      .rdata_i  (dmem.rdata),
      .lane_i   (lane),
      .funct3_i (f3_q),
      .data_o   (load_data)
   );

   // Request fields are forced to zero outside REQ so reset and idle show a quiet bus.
   assign dmem.req_valid = req;
   assign dmem.we        = req & store_q;
   assign dmem.addr      = req ? {addr_q[XLEN-1:LANE_W], {LANE_W{1'b0}}} : '0;
   assign dmem.wdata     = req ? wdata_rep : '0;
   assign dmem.be        = req ? (be_base << lane) : '0;
   assign stall_out      = (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      addr_d = addr_q;   wdata_d = wdata_q; pc_d = pc_q; rd_d = rd_q; f3_d = f3_q;
      store_d = store_q; rw_d = rw_q;       m2r_d = m2r_q;
      ov_d = 1'b0;       rwo_d = 1'b0;
      alu_o_d = alu_o_q; rd_data_d = rd_data_q; pc_o_d = pc_o_q; rd_o_d = rd_o_q; m2ro_d = m2ro_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && (!in_mem || trap_hit)) begin
               ov_d      = 1'b1;
               rwo_d     = reg_write_in & ~in_mem;
               alu_o_d   = alu_result_in;
               rd_data_d = '0;
               pc_o_d    = pc_plus_4_in;
               rd_o_d    = rd_addr_in;
               m2ro_d    = mem_to_reg_in;
            end else if (in_valid) begin
               addr_d  = alu_result_in;  wdata_d = rs2_data_in;  pc_d = pc_plus_4_in;
               rd_d    = rd_addr_in;     f3_d    = funct3_in;    store_d = mem_write_in;
               rw_d    = reg_write_in;   m2r_d   = mem_to_reg_in;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (dmem.req_ready) begin
               state_d = store_q ? S_IDLE : S_WAIT_RSP;
               if (store_q) begin
                  ov_d = 1'b1; rwo_d = rw_q; alu_o_d = addr_q; rd_data_d = '0;
                  pc_o_d = pc_q; rd_o_d = rd_q; m2ro_d = m2r_q;
               end
            end
         end
         S_WAIT_RSP: begin
            if (dmem.rsp_valid) begin
               state_d = S_IDLE;
               ov_d = 1'b1; rwo_d = rw_q; alu_o_d = addr_q; rd_data_d = load_data;
               pc_o_d = pc_q; rd_o_d = rd_q; m2ro_d = m2r_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q <= '0; wdata_q <= '0; pc_q <= '0; rd_q <= '0; f3_q <= '0;
         store_q <= 1'b0; rw_q <= 1'b0; m2r_q <= 1'b0;
         ov_q <= 1'b0; rwo_q <= 1'b0; m2ro_q <= 1'b0;
         alu_o_q <= '0; rd_data_q <= '0; pc_o_q <= '0; rd_o_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d; wdata_q <= wdata_d; pc_q <= pc_d; rd_q <= rd_d; f3_q <= f3_d;
         store_q <= store_d; rw_q <= rw_d; m2r_q <= m2r_d;
         ov_q <= ov_d; rwo_q <= rwo_d; m2ro_q <= m2ro_d;
         alu_o_q <= alu_o_d; rd_data_q <= rd_data_d; pc_o_q <= pc_o_d; rd_o_q <= rd_o_d;
      end
   end

   assign out_valid      = ov_q;
   assign alu_result_out = alu_o_q;
   assign read_data_out  = rd_data_q;
   assign rd_addr_out    = rd_o_q;
   assign pc_plus_4_out  = pc_o_q;
   assign reg_write_out  = rwo_q;
   assign mem_to_reg_out = m2ro_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of the MEM stage (XLEN=32).
`default_nettype none

module tb_mem_access_stage;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] alu_result_in, rs2_data_in, pc_plus_4_in;
   logic [4:0]  rd_addr_in;
   logic [2:0]  funct3_in;
   logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
   logic        stall_out, out_valid, reg_write_out, mem_to_reg_out;
   logic [31:0] alu_result_out, read_data_out, pc_plus_4_out;
   logic [4:0]  rd_addr_out;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_fault_out;
`endif

   int n_checks = 0;
   int n_errors = 0;

   mem_access_stage_if #(.XLEN(32)) dmem_if ();

   mem_access_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .alu_result_in  (alu_result_in),
      .rs2_data_in    (rs2_data_in),
      .rd_addr_in     (rd_addr_in),
      .pc_plus_4_in   (pc_plus_4_in),
      .funct3_in      (funct3_in),
      .mem_read_in    (mem_read_in),
      .mem_write_in   (mem_write_in),
      .reg_write_in   (reg_write_in),
      .mem_to_reg_in  (mem_to_reg_in),
      .stall_out      (stall_out),
      .dmem           (dmem_if),
      .out_valid      (out_valid),
      .alu_result_out (alu_result_out),
      .read_data_out  (read_data_out),
      .rd_addr_out    (rd_addr_out),
      .pc_plus_4_out  (pc_plus_4_out),
      .reg_write_out  (reg_write_out),
      .mem_to_reg_out (mem_to_reg_out)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign_fault_out (misalign_fault_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                          input int delay, input logic [31:0] exp_data, input logic [3:0] exp_be,
                          input string tag);
      int pulses;
      pulses = 0;
      in_valid = 1'b1; alu_result_in = addr; funct3_in = f3; mem_read_in = 1'b1;
      mem_write_in = 1'b0; reg_write_in = 1'b1; mem_to_reg_in = 1'b1; rd_addr_in = 5'd7;
      step();
      pulses += int'(out_valid);
      in_valid = 1'b0; mem_read_in = 1'b0; dmem_if.req_ready = 1'b1;
      chk({tag, "_req_valid"}, dmem_if.req_valid, 1'b1);
      chk({tag, "_be"}, dmem_if.be, exp_be);
      chk({tag, "_addr"}, dmem_if.addr, addr & 32'hFFFF_FFFC);
      step();
      pulses += int'(out_valid);
      dmem_if.req_ready = 1'b0;
      for (int i = 0; i < delay; i++) begin
         step();
         pulses += int'(out_valid);
      end
      chk({tag, "_wait_stall"}, stall_out, 1'b1);
      dmem_if.rsp_valid = 1'b1; dmem_if.rdata = rdata;
      step();
      dmem_if.rsp_valid = 1'b0; dmem_if.rdata = 32'h0;
      pulses += int'(out_valid);
      chk({tag, "_data"}, read_data_out, exp_data);
      chk({tag, "_rd"}, rd_addr_out, 5'd7);
      chk({tag, "_stall_done"}, stall_out, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         pulses += int'(out_valid);
      end
      chk({tag, "_pulses"}, pulses, 1);
   endtask

   initial begin
      int stall_cnt;
      rst_n = 1'b0; in_valid = 1'b0; alu_result_in = '0; rs2_data_in = '0; pc_plus_4_in = '0;
      rd_addr_in = '0; funct3_in = '0; mem_read_in = 1'b0; mem_write_in = 1'b0;
      reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
      dmem_if.req_ready = 1'b0; dmem_if.rsp_valid = 1'b0; dmem_if.rdata = '0;
      repeat (2) step();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_stall", stall_out, 1'b0);
      chk("rst_req_valid", dmem_if.req_valid, 1'b0);
      chk("rst_be", dmem_if.be, 4'h0);
      chk("rst_alu_out", alu_result_out, 32'h0);
      rst_n = 1'b1;
      step();

      // ALU pass-through
      in_valid = 1'b1; alu_result_in = 32'h1234; rd_addr_in = 5'd5; reg_write_in = 1'b1;
      pc_plus_4_in = 32'h104; funct3_in = 3'b000;
      chk("pt_stall_pre", stall_out, 1'b0);
      step();
      in_valid = 1'b0;
      chk("pt_out_valid", out_valid, 1'b1);
      chk("pt_alu", alu_result_out, 32'h1234);
      chk("pt_rd", rd_addr_out, 5'd5);
      chk("pt_pc", pc_plus_4_out, 32'h104);
      chk("pt_reg_write", reg_write_out, 1'b1);
      chk("pt_stall", stall_out, 1'b0);
      step();
      chk("pt_idle_valid", out_valid, 1'b0);
      chk("pt_idle_rw", reg_write_out, 1'b0);

      // SB at 0x1003, ready low for two cycles
      in_valid = 1'b1; alu_result_in = 32'h1003; rs2_data_in = 32'h0000_00AB; funct3_in = 3'b000;
      mem_write_in = 1'b1; reg_write_in = 1'b0; rd_addr_in = 5'd0;
      step();
      in_valid = 1'b0; mem_write_in = 1'b0;
      stall_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         stall_cnt += int'(stall_out);
         chk("sb_out_valid_low", out_valid, 1'b0);
         if (i == 1) begin
            chk("sb_be", dmem_if.be, 4'h8);
            chk("sb_wdata", dmem_if.wdata, 32'hABAB_ABAB);
            chk("sb_addr", dmem_if.addr, 32'h1000);
            chk("sb_we", dmem_if.we, 1'b1);
         end
         if (i == 2) dmem_if.req_ready = 1'b1;
         step();
      end
      dmem_if.req_ready = 1'b0;
      chk("sb_stall_cycles", stall_cnt, 3);
      chk("sb_out_valid", out_valid, 1'b1);
      chk("sb_stall_done", stall_out, 1'b0);
      chk("sb_req_drop", dmem_if.req_valid, 1'b0);
      step();
      chk("sb_pulse", out_valid, 1'b0);

      // Loads: sign/zero extension and lane selection
      do_load(32'h2001, 3'b000, 32'h0000_80FF, 0, 32'hFFFF_FF80, 4'h2, "lb");
      do_load(32'h2001, 3'b100, 32'h0000_80FF, 0, 32'h0000_0080, 4'h2, "lbu");
      do_load(32'h2002, 3'b001, 32'h8001_0000, 3, 32'hFFFF_8001, 4'hC, "lh");
      do_load(32'h2002, 3'b101, 32'h8001_0000, 1, 32'h0000_8001, 4'hC, "lhu");
      do_load(32'h2000, 3'b010, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'hF, "lw");
      do_load(32'h2000, 3'b011, 32'h1357_9BDF, 0, 32'h1357_9BDF, 4'hF, "ld_as_lw");
`ifndef MEM_MISALIGN_TRAP_EN
      do_load(32'h2003, 3'b001, 32'h8001_0000, 0, 32'hFFFF_8001, 4'hC, "lh_masked");
`endif

      // Reset in WAIT_RSP, then a stray response
      in_valid = 1'b1; alu_result_in = 32'h2004; funct3_in = 3'b010; mem_read_in = 1'b1;
      reg_write_in = 1'b1;
      step();
      in_valid = 1'b0; mem_read_in = 1'b0; dmem_if.req_ready = 1'b1;
      step();
      dmem_if.req_ready = 1'b0;
      chk("rstmid_in_wait", stall_out, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_stall", stall_out, 1'b0);
      chk("rstmid_req", dmem_if.req_valid, 1'b0);
      step();
      rst_n = 1'b1; dmem_if.rsp_valid = 1'b1; dmem_if.rdata = 32'hFFFF_FFFF;
      step();
      dmem_if.rsp_valid = 1'b0;
      chk("rstmid_no_valid", out_valid, 1'b0);
      chk("rstmid_rdata", read_data_out, 32'h0);
      chk("rstmid_rw", reg_write_out, 1'b0);
      step();
      chk("rstmid_still_idle", out_valid, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
      in_valid = 1'b1; alu_result_in = 32'h3002; funct3_in = 3'b010; mem_read_in = 1'b1;
      reg_write_in = 1'b1;
      chk("mis_no_req_pre", dmem_if.req_valid, 1'b0);
      step();
      in_valid = 1'b0; mem_read_in = 1'b0;
      chk("mis_out_valid", out_valid, 1'b1);
      chk("mis_fault", misalign_fault_out, 1'b1);
      chk("mis_reg_write", reg_write_out, 1'b0);
      chk("mis_no_req", dmem_if.req_valid, 1'b0);
      chk("mis_stall", stall_out, 1'b0);
      step();
      chk("mis_fault_clear", misalign_fault_out, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
